// File: rtl/fgu_frf_wr_sched.sv
// FRF write-port scheduler: merges FGU result, buffered load return and divide result onto w1/w2.
// Optional FGU_FRF_WR_SCHED_PERF_EN adds a saturating load-head stall counter output.
module fgu_frf_wr_sched #(
  parameter int LD_DEPTH = 2,
  parameter int DW       = 64,
  parameter int EW       = 14
) (
  input  logic          l2clk_i,
  input  logic          arst_l_i,
  input  logic [2:0]    fpu_tid_i,
  input  logic [4:0]    fpu_addr_i,
  input  logic [1:0]    fpu_valid_i,
  input  logic [DW-1:0] fpu_data_i,
  input  logic [EW-1:0] fpu_ecc_i,
  input  logic [2:0]    ld_tid_i,
  input  logic [4:0]    ld_addr_i,
  input  logic [1:0]    ld_valid_i,
  input  logic [DW-1:0] ld_data_i,
  input  logic [EW-1:0] ld_ecc_i,
  output logic          ld_full_o,
  output logic          ld_ovfl_err_o,
  input  logic [2:0]    div_tid_i,
  input  logic [4:0]    div_addr_i,
  input  logic [1:0]    div_valid_i,
  input  logic [DW-1:0] div_data_i,
  input  logic [EW-1:0] div_ecc_i,
  output logic          div_ready_o,
  output logic [2:0]    w1_tid_o,
  output logic [4:0]    w1_addr_o,
  output logic [1:0]    w1_valid_o,
  output logic [DW-1:0] w1_data_o,
  output logic [EW-1:0] w1_ecc_o,
  output logic [2:0]    w2_tid_o,
  output logic [4:0]    w2_addr_o,
  output logic [1:0]    w2_valid_o,
  output logic [DW-1:0] w2_data_o,
  output logic [EW-1:0] w2_ecc_o,
  output logic          sched_idle_o
`ifdef FGU_FRF_WR_SCHED_PERF_EN
  ,
  output logic [15:0]   perf_ld_stall_o
`endif
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = $clog2(LD_DEPTH + 1);

  typedef struct packed {
    logic [2:0]    tid;
    logic [4:0]    addr;
    logic [1:0]    valid;
    logic [EW-1:0] ecc;
    logic [DW-1:0] data;
  } wr_t;

  function automatic logic same_tgt(input wr_t a, input wr_t b);
    return {a.tid, a.addr} == {b.tid, b.addr};
  endfunction

  wr_t           fpu_w, ld_w, div_w, head_w;
  wr_t           w1_d, w2_d, w1_q, w2_q;
  wr_t           fifo_q [LD_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fpu_req, ld_req, div_req, head_v, full;
  logic          pick_ld, pick_div, ld_iss, div_iss, push, ovfl_set;
  logic          rr_div_q, rr_d, ovfl_q, idle_q;

  assign fpu_w   = '{tid: fpu_tid_i, addr: fpu_addr_i, valid: fpu_valid_i, ecc: fpu_ecc_i, data: fpu_data_i};
  assign ld_w    = '{tid: ld_tid_i,  addr: ld_addr_i,  valid: ld_valid_i,  ecc: ld_ecc_i,  data: ld_data_i};
  assign div_w   = '{tid: div_tid_i, addr: div_addr_i, valid: div_valid_i, ecc: div_ecc_i, data: div_data_i};
  assign head_w  = fifo_q[rd_ptr_q];
  assign fpu_req = fpu_valid_i != 2'b00;
  assign ld_req  = ld_valid_i != 2'b00;
  assign div_req = div_valid_i != 2'b00;
  assign head_v  = cnt_q != '0;
  assign full    = cnt_q == CW'(LD_DEPTH);

  // rr_div_q=1 means the next contended w2 grant goes to div; a held loser leaves it unchanged.
  always_comb begin
    w1_d     = '0;
    w2_d     = '0;
    ld_iss   = 1'b0;
    div_iss  = 1'b0;
    pick_ld  = 1'b0;
    pick_div = 1'b0;
    rr_d     = rr_div_q;
    if (fpu_req) begin
      w1_d     = fpu_w;
      pick_ld  = head_v && (!div_req || full || !rr_div_q);
      pick_div = div_req && !pick_ld;
      if (pick_ld && !same_tgt(fpu_w, head_w)) begin
        w2_d   = head_w;
        ld_iss = 1'b1;
      end else if (pick_div && !same_tgt(fpu_w, div_w)) begin
        w2_d    = div_w;
        div_iss = 1'b1;
      end
      if (head_v && div_req && (ld_iss || div_iss)) rr_d = ld_iss;
    end else begin
      if (head_v) begin
        w1_d   = head_w;
        ld_iss = 1'b1;
      end
      if (div_req && !(head_v && same_tgt(head_w, div_w))) begin
        w2_d    = div_w;
        div_iss = 1'b1;
      end
    end
  end

  // A push at full is only accepted when the head leaves in the same cycle.
  assign push     = ld_req && (!full || ld_iss);
  assign ovfl_set = ld_req && full && !ld_iss;
  assign cnt_d    = cnt_q + CW'(push) - CW'(ld_iss);

  always_ff @(posedge l2clk_i or negedge arst_l_i) begin
    if (!arst_l_i) begin
      w1_q     <= '0;
      w2_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      rr_div_q <= 1'b0;
      ovfl_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      w1_q     <= w1_d;
      w2_q     <= w2_d;
      cnt_q    <= cnt_d;
      rr_div_q <= rr_d;
      ovfl_q   <= ovfl_q | ovfl_set;
      idle_q   <= (cnt_d == '0) && !fpu_req && !div_req;
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (ld_iss) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge l2clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= ld_w;
  end

`ifdef FGU_FRF_WR_SCHED_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge l2clk_i or negedge arst_l_i) begin
    if (!arst_l_i)                                   perf_q <= '0;
    else if (head_v && !ld_iss && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end
  assign perf_ld_stall_o = perf_q;
`endif

  assign ld_full_o     = full;
  assign ld_ovfl_err_o = ovfl_q;
  assign div_ready_o   = div_iss;
  assign sched_idle_o  = idle_q;
  assign w1_tid_o      = w1_q.tid;
  assign w1_addr_o     = w1_q.addr;
  assign w1_valid_o    = w1_q.valid;
  assign w1_data_o     = w1_q.data;
  assign w1_ecc_o      = w1_q.ecc;
  assign w2_tid_o      = w2_q.tid;
  assign w2_addr_o     = w2_q.addr;
  assign w2_valid_o    = w2_q.valid;
  assign w2_data_o     = w2_q.data;
  assign w2_ecc_o      = w2_q.ecc;

endmodule

// File: tb/tb_fgu_frf_wr_sched.sv
// Bench for fgu_frf_wr_sched: directed table, hand sequences, then random traffic vs a queue model.
module tb_fgu_frf_wr_sched;
  localparam int DEPTH = 2;

  typedef enum logic [1:0] {S_NONE, S_FPU, S_LD, S_DIV} src_e;

  typedef struct packed {
    logic [2:0]  tid;
    logic [4:0]  addr;
    logic [1:0]  valid;
    logic [13:0] ecc;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    int ft, fa, fv;
    int lt, la, lv;
    int dt, da, dv;
    bit e_dr, e_full;
    src_e w1s; int w1t, w1a, w1v;
    src_e w2s; int w2t, w2a, w2v;
    bit e_idle;
  } tab_t;

  logic l2clk = 1'b0;
  logic arst_l = 1'b0;
  wr_t fpu_in = '0, ld_in = '0, div_in = '0;
  logic [2:0]  w1_tid, w2_tid;
  logic [4:0]  w1_addr, w2_addr;
  logic [1:0]  w1_valid, w2_valid;
  logic [63:0] w1_data, w2_data;
  logic [13:0] w1_ecc, w2_ecc;
  logic ld_full, ld_ovfl_err, div_ready, sched_idle;
`ifdef FGU_FRF_WR_SCHED_PERF_EN
  logic [15:0] perf;
`endif
  wr_t dut_w1, dut_w2;

  always #5 l2clk = ~l2clk;

  fgu_frf_wr_sched #(.LD_DEPTH(DEPTH), .DW(64), .EW(14)) dut (
    .l2clk_i(l2clk), .arst_l_i(arst_l),
    .fpu_tid_i(fpu_in.tid), .fpu_addr_i(fpu_in.addr), .fpu_valid_i(fpu_in.valid),
    .fpu_data_i(fpu_in.data), .fpu_ecc_i(fpu_in.ecc),
    .ld_tid_i(ld_in.tid), .ld_addr_i(ld_in.addr), .ld_valid_i(ld_in.valid),
    .ld_data_i(ld_in.data), .ld_ecc_i(ld_in.ecc),
    .ld_full_o(ld_full), .ld_ovfl_err_o(ld_ovfl_err),
    .div_tid_i(div_in.tid), .div_addr_i(div_in.addr), .div_valid_i(div_in.valid),
    .div_data_i(div_in.data), .div_ecc_i(div_in.ecc), .div_ready_o(div_ready),
    .w1_tid_o(w1_tid), .w1_addr_o(w1_addr), .w1_valid_o(w1_valid), .w1_data_o(w1_data), .w1_ecc_o(w1_ecc),
    .w2_tid_o(w2_tid), .w2_addr_o(w2_addr), .w2_valid_o(w2_valid), .w2_data_o(w2_data), .w2_ecc_o(w2_ecc),
    .sched_idle_o(sched_idle)
`ifdef FGU_FRF_WR_SCHED_PERF_EN
    , .perf_ld_stall_o(perf)
`endif
  );

  assign dut_w1 = {w1_tid, w1_addr, w1_valid, w1_ecc, w1_data};
  assign dut_w2 = {w2_tid, w2_addr, w2_valid, w2_ecc, w2_data};

  int checks = 0;
  int errors = 0;

  // Reference state: pending loads as a queue, who gets the next contended w2 slot, sticky overflow.
  wr_t  mq[$];
  logic m_rr_div = 1'b0;
  logic m_ovfl = 1'b0;
  logic m_dr = 1'b0;

  function automatic wr_t mk(src_e s, int t, int a, int v);
    wr_t w;
    w = '0;
    if (v != 0) begin
      w.tid   = 3'(t);
      w.addr  = 5'(a);
      w.valid = 2'(v);
      w.ecc   = {s, 4'hA, 3'(t), 5'(a)};
      w.data  = {4'(s), 52'h0123456789ABC, 3'(t), 5'(a)};
    end
    return w;
  endfunction

  function automatic bit same(wr_t a, wr_t b);
    return (a.tid == b.tid) && (a.addr == b.addr);
  endfunction

  function automatic wr_t pick(src_e s, wr_t head);
    case (s)
      S_FPU:   return fpu_in;
      S_LD:    return head;
      S_DIV:   return div_in;
      default: return '0;
    endcase
  endfunction

  task automatic chk(string nm, logic [87:0] act, logic [87:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge with inputs already driven; leaves time just after the next edge.
  task automatic cycle(input bit use_t, input tab_t r);
    wr_t head, e1, e2;
    src_e s1, s2, cand;
    bit f, d, hv, full0, both;
    logic e_idle;
    #1;
    hv    = mq.size() > 0;
    full0 = mq.size() == DEPTH;
    head  = hv ? mq[0] : '0;
    f     = fpu_in.valid != 0;
    d     = div_in.valid != 0;
    s1    = S_NONE;
    s2    = S_NONE;
    if (f) begin
      s1   = S_FPU;
      both = hv && d;
      if (both)    cand = (full0 || !m_rr_div) ? S_LD : S_DIV;
      else if (hv) cand = S_LD;
      else if (d)  cand = S_DIV;
      else         cand = S_NONE;
      if (cand == S_LD && same(fpu_in, head))    cand = S_NONE;
      if (cand == S_DIV && same(fpu_in, div_in)) cand = S_NONE;
      s2 = cand;
      if (both && cand != S_NONE) m_rr_div = (cand == S_LD);
    end else begin
      if (hv) s1 = S_LD;
      if (d && !(hv && same(head, div_in))) s2 = S_DIV;
    end
    e1   = pick(s1, head);
    e2   = pick(s2, head);
    m_dr = (s2 == S_DIV);
    chk("div_ready", div_ready, m_dr);
    chk("ld_full", ld_full, full0);
    if (use_t) begin
      chk("tab_div_ready", div_ready, r.e_dr);
      chk("tab_ld_full", ld_full, r.e_full);
    end
    if (s1 == S_LD || s2 == S_LD) void'(mq.pop_front());
    if (ld_in.valid != 0) begin
      if (mq.size() < DEPTH) mq.push_back(ld_in);
      else m_ovfl = 1'b1;
    end
    e_idle = (mq.size() == 0) && !f && !d;
    @(posedge l2clk);
    #1;
    chk("w1", dut_w1, e1);
    chk("w2", dut_w2, e2);
    chk("sched_idle", sched_idle, e_idle);
    chk("ld_ovfl_err", ld_ovfl_err, m_ovfl);
    if (use_t) begin
      chk("tab_w1", dut_w1, mk(r.w1s, r.w1t, r.w1a, r.w1v));
      chk("tab_w2", dut_w2, mk(r.w2s, r.w2t, r.w2a, r.w2v));
      chk("tab_idle", sched_idle, r.e_idle);
    end
  endtask

  task automatic drive(int ft, int fa, int fv, int lt, int la, int lv, int dt, int da, int dv);
    fpu_in = mk(S_FPU, ft, fa, fv);
    ld_in  = mk(S_LD, lt, la, lv);
    div_in = mk(S_DIV, dt, da, dv);
  endtask

  task automatic step(int ft, int fa, int fv, int lt, int la, int lv, int dt, int da, int dv);
    tab_t z;
    z = '{0,0,0, 0,0,0, 0,0,0, 0,0, S_NONE,0,0,0, S_NONE,0,0,0, 0};
    drive(ft, fa, fv, lt, la, lv, dt, da, dv);
    cycle(1'b0, z);
  endtask

  tab_t tab[13];

  initial begin
    tab[0]  = '{2,5,3,  0,0,0,  0,0,0,  0,0, S_FPU,2,5,3,  S_NONE,0,0,0,  0};
    tab[1]  = '{0,1,3,  1,1,1,  3,3,2,  1,0, S_FPU,0,1,3,  S_DIV,3,3,2,   0};
    tab[2]  = '{0,2,3,  1,2,1,  3,4,2,  0,0, S_FPU,0,2,3,  S_LD,1,1,1,    0};
    tab[3]  = '{0,3,3,  1,3,1,  3,4,2,  1,0, S_FPU,0,3,3,  S_DIV,3,4,2,   0};
    tab[4]  = '{0,4,3,  0,0,0,  3,5,2,  0,1, S_FPU,0,4,3,  S_LD,1,2,1,    0};
    tab[5]  = '{0,5,3,  0,0,0,  3,5,2,  1,0, S_FPU,0,5,3,  S_DIV,3,5,2,   0};
    tab[6]  = '{0,0,0,  0,0,0,  4,31,3, 1,0, S_LD,1,3,1,   S_DIV,4,31,3,  0};
    tab[7]  = '{0,0,0,  4,31,3, 0,0,0,  0,0, S_NONE,0,0,0, S_NONE,0,0,0,  0};
    tab[8]  = '{0,0,0,  0,0,0,  4,31,1, 0,0, S_LD,4,31,3,  S_NONE,0,0,0,  0};
    tab[9]  = '{0,0,0,  0,0,0,  4,31,1, 1,0, S_NONE,0,0,0, S_DIV,4,31,1,  0};
    tab[10] = '{6,7,1,  0,0,0,  6,7,2,  0,0, S_FPU,6,7,1,  S_NONE,0,0,0,  0};
    tab[11] = '{0,0,0,  0,0,0,  6,7,2,  1,0, S_NONE,0,0,0, S_DIV,6,7,2,   0};
    tab[12] = '{0,0,0,  0,0,0,  0,0,0,  0,0, S_NONE,0,0,0, S_NONE,0,0,0,  1};

    #12;
    chk("rst_w1", dut_w1, '0);
    chk("rst_w2", dut_w2, '0);
    chk("rst_ld_full", ld_full, 1'b0);
    chk("rst_ovfl", ld_ovfl_err, 1'b0);
    chk("rst_idle", sched_idle, 1'b1);
    arst_l = 1'b1;
    @(posedge l2clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(tab[i].ft, tab[i].fa, tab[i].fv, tab[i].lt, tab[i].la, tab[i].lv,
            tab[i].dt, tab[i].da, tab[i].dv);
      cycle(1'b1, tab[i]);
    end

    // Overflow: head blocked by fpu on the same target, third load dropped, then legal push+pop at full.
    step(0,0,3, 5,1,3, 0,0,0);
    step(5,1,3, 5,2,3, 0,0,0);
    chk("full_after_2", ld_full, 1'b1);
    step(5,1,3, 5,3,3, 0,0,0);
    chk("ovfl_set", ld_ovfl_err, 1'b1);
    step(0,0,0, 5,4,3, 0,0,0);
    chk("drain_A", dut_w1, mk(S_LD,5,1,3));
    chk("full_pushpop", ld_full, 1'b1);
    step(0,0,0, 0,0,0, 0,0,0);
    chk("drain_B", dut_w1, mk(S_LD,5,2,3));
    step(0,0,0, 0,0,0, 0,0,0);
    chk("drain_D", dut_w1, mk(S_LD,5,4,3));
    step(0,0,0, 0,0,0, 0,0,0);
    chk("dropped_C", w1_valid, 2'b00);

    // Reset with two queued loads and a held divide request.
    step(0,0,3, 5,1,3, 0,0,0);
    step(5,1,3, 5,2,3, 5,1,3);
    chk("pre_rst_full", ld_full, 1'b1);
    drive(0,0,0, 0,0,0, 0,0,0);
    #2 arst_l = 1'b0;
    #1;
    chk("arst_w1v", w1_valid, 2'b00);
    chk("arst_w2v", w2_valid, 2'b00);
    chk("arst_full", ld_full, 1'b0);
    chk("arst_idle", sched_idle, 1'b1);
    chk("arst_ovfl", ld_ovfl_err, 1'b0);
    @(posedge l2clk);
    #1;
    chk("arst_hold_w1v", w1_valid, 2'b00);
    #2 arst_l = 1'b1;
    mq.delete();
    m_rr_div = 1'b0;
    m_ovfl   = 1'b0;
    @(posedge l2clk);
    #1;
    for (int i = 0; i < 3; i++) step(0,0,0, 0,0,0, 0,0,0);

`ifdef FGU_FRF_WR_SCHED_PERF_EN
    step(0,0,0, 1,1,3, 0,0,0);
    for (int i = 0; i < 10; i++) step(1,1,3, 0,0,0, 0,0,0);
    chk("perf_10", perf, 16'd10);
    step(0,0,0, 0,0,0, 0,0,0);
    chk("perf_hold", perf, 16'd10);
`endif

    // Random traffic on a small target space so same-target collisions occur.
    for (int n = 0; n < 600; n++) begin
      tab_t z;
      z = '{0,0,0, 0,0,0, 0,0,0, 0,0, S_NONE,0,0,0, S_NONE,0,0,0, 0};
      if ($urandom_range(0, 2) != 0)
        fpu_in = mk(S_FPU, $urandom_range(0,1), $urandom_range(0,3), $urandom_range(1,3));
      else
        fpu_in = '0;
      if (mq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        ld_in = mk(S_LD, $urandom_range(0,1), $urandom_range(0,3), $urandom_range(1,3));
        ld_in.data = {$urandom, $urandom};
      end else begin
        ld_in = '0;
      end
      if (div_in.valid == 0 && $urandom_range(0, 1) == 1) begin
        div_in = mk(S_DIV, $urandom_range(0,1), $urandom_range(0,3), $urandom_range(1,3));
        div_in.data = {$urandom, $urandom};
      end
      cycle(1'b0, z);
      if (m_dr) div_in = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
